// File: rtl/pa_ifu_icache_tag_ctrl_pkg.sv
// Shared constants for the IFU icache tag controller: 2-way tag word layout,
// write-enable slots, FSM encodings and the lookup result record.
package pa_ifu_icache_tag_ctrl_pkg;

  localparam int TAG_WORD_W  = 47;
  localparam int TAG_IDX_W   = 10;
  localparam int TAG_FIELD_W = 22;

  localparam int FIFO_BIT   = 46;
  localparam int W1_VLD     = 45;
  localparam int W0_VLD     = 22;
  localparam int W1_TAG_LSB = 23;
  localparam int W0_TAG_LSB = 0;

  localparam logic [2:0] WEN_NONE = 3'b000;
  localparam logic [2:0] WEN_W0   = 3'b001;
  localparam logic [2:0] WEN_W1   = 3'b010;
  localparam logic [2:0] WEN_FIFO = 3'b100;
  localparam logic [2:0] WEN_ALL  = 3'b111;

  typedef enum logic [1:0] {
    TAG_ST_IDLE     = 2'd0,
    TAG_ST_INV      = 2'd1,
    TAG_ST_INV_DONE = 2'd2
  } tag_state_e;

  typedef struct packed {
    logic hit;
    logic hit_way;
    logic victim_way;
    logic multihit;
  } tag_result_t;

  // Fifo bit points at the way that was not just filled, so it is evicted next.
  function automatic logic [TAG_WORD_W-1:0] refill_word(input logic                   way,
                                                        input logic [TAG_FIELD_W-1:0] tag);
    logic [TAG_WORD_W-1:0] w;
    w           = '0;
    w[FIFO_BIT] = ~way;
    if (way) begin
      w[W1_VLD]                         = 1'b1;
      w[W1_TAG_LSB +: TAG_FIELD_W]      = tag;
    end else begin
      w[W0_VLD]                         = 1'b1;
      w[W0_TAG_LSB +: TAG_FIELD_W]      = tag;
    end
    return w;
  endfunction

  function automatic logic [2:0] refill_wen(input logic way);
    return WEN_FIFO | (way ? WEN_W1 : WEN_W0);
  endfunction

endpackage

// File: rtl/pa_ifu_icache_tag_ctrl_if.sv
// Request/response and tag-array port bundle of the icache tag controller.
// slave: the controller itself; master: fetch, refill FSM and tag array side.
interface pa_ifu_icache_tag_ctrl_if #(
  parameter int TAG_WIDTH = 22
);
  import pa_ifu_icache_tag_ctrl_pkg::*;

  logic                  inv_all_req;
  logic                  inv_busy;
  logic                  inv_done;

  logic                  refill_req;
  logic [TAG_IDX_W-1:0]  refill_idx;
  logic [TAG_WIDTH-1:0]  refill_tag;
  logic                  refill_way;
  logic                  refill_rdy;

  logic                  lookup_req;
  logic [TAG_IDX_W-1:0]  lookup_idx;
  logic [TAG_WIDTH-1:0]  lookup_tag;
  logic                  lookup_rdy;
  logic                  lookup_resp_vld;
  logic                  lookup_hit;
  logic                  lookup_hit_way;
  logic                  lookup_victim_way;
  logic                  lookup_multihit;

  logic                  icache_tag_cen;
  logic [2:0]            icache_tag_wen;
  logic [TAG_IDX_W-1:0]  icache_tag_idx;
  logic [TAG_WORD_W-1:0] icache_tag_din;
  logic [TAG_WORD_W-1:0] icache_tag_dout;

  modport slave (
    input  inv_all_req,
    output inv_busy, inv_done,
    input  refill_req, refill_idx, refill_tag, refill_way,
    output refill_rdy,
    input  lookup_req, lookup_idx, lookup_tag,
    output lookup_rdy, lookup_resp_vld, lookup_hit, lookup_hit_way,
    output lookup_victim_way, lookup_multihit,
    output icache_tag_cen, icache_tag_wen, icache_tag_idx, icache_tag_din,
    input  icache_tag_dout
  );

  modport master (
    output inv_all_req,
    input  inv_busy, inv_done,
    output refill_req, refill_idx, refill_tag, refill_way,
    input  refill_rdy,
    output lookup_req, lookup_idx, lookup_tag,
    input  lookup_rdy, lookup_resp_vld, lookup_hit, lookup_hit_way,
    input  lookup_victim_way, lookup_multihit,
    input  icache_tag_cen, icache_tag_wen, icache_tag_idx, icache_tag_din,
    output icache_tag_dout
  );

endinterface

// File: rtl/pa_ifu_icache_tag_cmp.sv
// Per-way tag compare and victim select on one 2-way tag word; purely combinational.
module pa_ifu_icache_tag_cmp
  import pa_ifu_icache_tag_ctrl_pkg::*;
#(
  parameter int TAG_WIDTH = 22
) (
  input  logic [TAG_WORD_W-1:0] dout_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output tag_result_t           res_o
);

  logic vld0;
  logic vld1;
  logic hit0;
  logic hit1;

  assign vld0 = dout_i[W0_VLD];
  assign vld1 = dout_i[W1_VLD];
  assign hit0 = vld0 & (dout_i[W0_TAG_LSB +: TAG_WIDTH] == tag_i);
  assign hit1 = vld1 & (dout_i[W1_TAG_LSB +: TAG_WIDTH] == tag_i);

  always_comb begin
    res_o          = '0;
    res_o.hit      = hit0 | hit1;
    res_o.hit_way  = hit1 & ~hit0;
    res_o.multihit = hit0 & hit1;
    // Fill empty ways first; only a full set falls back to the fifo bit.
    if (!vld0) begin
      res_o.victim_way = 1'b0;
    end else if (!vld1) begin
      res_o.victim_way = 1'b1;
    end else begin
      res_o.victim_way = dout_i[FIFO_BIT];
    end
  end

endmodule

// File: rtl/pa_ifu_icache_tag_ctrl.sv
// Icache tag array controller: invalidate sweep > refill write > fetch lookup.
// Lookup result two cycles after acceptance, one per cycle; rdy gates requests.
module pa_ifu_icache_tag_ctrl
  import pa_ifu_icache_tag_ctrl_pkg::*;
#(
  parameter int TAG_WIDTH   = 22,
  parameter int INDEX_WIDTH = 5
) (
  input logic                    forever_cpuclk,
  input logic                    cpurst,
  pa_ifu_icache_tag_ctrl_if.slave bus
);

  tag_state_e              state_q;
  logic [INDEX_WIDTH-1:0]  inv_cnt_q;
  logic                    inv_busy_q;
  logic                    inv_done_q;

  logic                    inv_wr;
  logic                    in_idle;
  logic                    refill_rdy;
  logic                    lookup_rdy;
  logic                    refill_fire;
  logic                    lookup_fire;

  logic [TAG_IDX_W-1:0]    inv_idx;
  logic [TAG_IDX_W-1:0]    refill_idx_m;
  logic [TAG_IDX_W-1:0]    lookup_idx_m;
  logic                    unused_idx_hi;

  logic                    arr_cen;
  logic [2:0]              arr_wen;
  logic [TAG_IDX_W-1:0]    idx_d;
  logic [TAG_IDX_W-1:0]    idx_q;
  logic [TAG_WORD_W-1:0]   din_d;
  logic [TAG_WORD_W-1:0]   din_q;

  logic                    lk_vld_q;
  logic [TAG_WIDTH-1:0]    lk_tag_q;
  logic                    rsp_vld_q;
  tag_result_t             cmp_res;
  tag_result_t             rsp_q;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= TAG_ST_INV;
      inv_cnt_q  <= '0;
      inv_busy_q <= 1'b1;
      inv_done_q <= 1'b0;
    end else begin
      inv_done_q <= 1'b0;
      case (state_q)
        TAG_ST_IDLE: begin
          if (bus.inv_all_req) begin
            state_q    <= TAG_ST_INV;
            inv_cnt_q  <= '0;
            inv_busy_q <= 1'b1;
          end
        end
        TAG_ST_INV: begin
          inv_cnt_q <= inv_cnt_q + INDEX_WIDTH'(1);
          if (&inv_cnt_q) begin
            state_q    <= TAG_ST_INV_DONE;
            inv_busy_q <= 1'b0;
            inv_done_q <= 1'b1;
          end
        end
        TAG_ST_INV_DONE: begin
          state_q <= TAG_ST_IDLE;
        end
        default: begin
          state_q    <= TAG_ST_INV;
          inv_cnt_q  <= '0;
          inv_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Reset is folded in combinationally so the array port is quiet from the first reset cycle.
  assign inv_wr      = ~cpurst & (state_q == TAG_ST_INV);
  assign in_idle     = ~cpurst & (state_q == TAG_ST_IDLE);
  assign refill_rdy  = in_idle & ~bus.inv_all_req;
  assign lookup_rdy  = refill_rdy & ~bus.refill_req;
  assign refill_fire = refill_rdy & bus.refill_req;
  assign lookup_fire = lookup_rdy & bus.lookup_req;

  assign inv_idx       = {{(TAG_IDX_W-INDEX_WIDTH){1'b0}}, inv_cnt_q};
  assign refill_idx_m  = {{(TAG_IDX_W-INDEX_WIDTH){1'b0}}, bus.refill_idx[INDEX_WIDTH-1:0]};
  assign lookup_idx_m  = {{(TAG_IDX_W-INDEX_WIDTH){1'b0}}, bus.lookup_idx[INDEX_WIDTH-1:0]};
  assign unused_idx_hi = ^{bus.refill_idx[TAG_IDX_W-1:INDEX_WIDTH],
                           bus.lookup_idx[TAG_IDX_W-1:INDEX_WIDTH]};

  always_comb begin
    arr_cen = 1'b0;
    arr_wen = WEN_NONE;
    idx_d   = idx_q;
    din_d   = din_q;
    if (inv_wr) begin
      arr_cen = 1'b1;
      arr_wen = WEN_ALL;
      idx_d   = inv_idx;
      din_d   = '0;
    end else if (refill_fire) begin
      arr_cen = 1'b1;
      arr_wen = refill_wen(bus.refill_way);
      idx_d   = refill_idx_m;
      din_d   = refill_word(bus.refill_way, TAG_FIELD_W'(bus.refill_tag));
    end else if (lookup_fire) begin
      arr_cen = 1'b1;
      idx_d   = lookup_idx_m;
    end
  end

  // idx/din keep their last driven value across idle cycles.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      idx_q <= '0;
      din_q <= '0;
    end else begin
      idx_q <= idx_d;
      din_q <= din_d;
    end
  end

  assign bus.icache_tag_cen = arr_cen;
  assign bus.icache_tag_wen = arr_wen;
  assign bus.icache_tag_idx = cpurst ? '0 : idx_d;
  assign bus.icache_tag_din = cpurst ? '0 : din_d;

  always_ff @(posedge forever_cpuclk) begin
    if (lookup_fire) begin
      lk_tag_q <= bus.lookup_tag;
    end
  end

  pa_ifu_icache_tag_cmp #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_cmp (
    .dout_i (bus.icache_tag_dout),
    .tag_i  (lk_tag_q),
    .res_o  (cmp_res)
  );

  // In-flight lookups are not cancelled by an invalidate request, only by reset.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      lk_vld_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      lk_vld_q  <= lookup_fire;
      rsp_vld_q <= lk_vld_q;
      if (lk_vld_q) begin
        rsp_q <= cmp_res;
      end
    end
  end

  assign bus.inv_busy          = cpurst | inv_busy_q;
  assign bus.inv_done          = ~cpurst & inv_done_q;
  assign bus.refill_rdy        = refill_rdy;
  assign bus.lookup_rdy        = lookup_rdy;
  assign bus.lookup_resp_vld   = ~cpurst & rsp_vld_q;
  assign bus.lookup_hit        = rsp_q.hit;
  assign bus.lookup_hit_way    = rsp_q.hit_way;
  assign bus.lookup_victim_way = rsp_q.victim_way;
  assign bus.lookup_multihit   = rsp_q.multihit;

endmodule

// File: tb/tb_pa_ifu_icache_tag_ctrl.sv
// Bench for pa_ifu_icache_tag_ctrl: behavioural 1-cycle tag array, vector table,
// response scoreboard and hand-written sweep/reset/ordering sequences.
module tb_pa_ifu_icache_tag_ctrl;

  localparam int TW = 22;
  localparam int IW = 5;
  localparam logic [46:0] GARBAGE = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pa_ifu_icache_tag_ctrl_if #(.TAG_WIDTH(TW)) bus ();

  pa_ifu_icache_tag_ctrl #(
    .TAG_WIDTH   (TW),
    .INDEX_WIDTH (IW)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Tag array model; never-written entries read back as all ones.
  logic [46:0] mem [1024];
  bit          written [1024];
  always @(posedge clk) begin
    int          i;
    logic [46:0] cur;
    if (bus.icache_tag_cen === 1'b1) begin
      i   = int'(bus.icache_tag_idx);
      cur = written[i] ? mem[i] : GARBAGE;
      if (bus.icache_tag_wen == 3'b000) begin
        bus.icache_tag_dout <= cur;
      end else begin
        if (bus.icache_tag_wen[2]) cur[46]    = bus.icache_tag_din[46];
        if (bus.icache_tag_wen[1]) cur[45:23] = bus.icache_tag_din[45:23];
        if (bus.icache_tag_wen[0]) cur[22:0]  = bus.icache_tag_din[22:0];
        mem[i]     <= cur;
        written[i] <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic hit;
    logic hit_way;
    logic victim;
    logic multi;
  } rsp_t;

  typedef struct {
    rsp_t r;
    int   due;
  } exp_t;

  typedef struct {
    bit          is_lk;
    logic [9:0]  idx;
    logic [21:0] tag;
    logic        way;
    rsp_t        exp;
  } vec_t;

  exp_t sb[$];
  rsp_t cur_exp;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Negedge sample: retire responses, record accepted requests, check array port use.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due < cyc_cnt) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL resp_missing: no response by cycle %0d, required at %0d", cyc_cnt, e.due);
    end
    if (bus.lookup_resp_vld === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: resp_vld=1 at cycle %0d, none required", cyc_cnt);
      end else begin
        e = sb.pop_front();
        chk("resp_val", {bus.lookup_hit, bus.lookup_hit_way, bus.lookup_victim_way,
                         bus.lookup_multihit}, e.r);
        chk("resp_cycle", cyc_cnt, e.due);
      end
    end
    if (rst == 1'b0 && bus.lookup_req && bus.lookup_rdy === 1'b1) begin
      e.r   = cur_exp;
      e.due = cyc_cnt + 2;
      sb.push_back(e);
      chk("lookup_port", {bus.icache_tag_cen, bus.icache_tag_wen, bus.icache_tag_idx},
          {1'b1, 3'b000, bus.lookup_idx & 10'h01F});
    end
    if (rst == 1'b0 && bus.refill_req && bus.refill_rdy === 1'b1) begin
      chk("refill_port", {bus.icache_tag_cen, bus.icache_tag_wen, bus.icache_tag_idx},
          {1'b1, 1'b1, bus.refill_way, ~bus.refill_way, bus.refill_idx & 10'h01F});
      chk("refill_din", {bus.icache_tag_din[46],
                         bus.refill_way ? bus.icache_tag_din[45:23] : bus.icache_tag_din[22:0]},
          {~bus.refill_way, 1'b1, bus.refill_tag});
    end
  endtask

  task automatic cyc();
    sample();
    to_drive();
  endtask

  // Starts at the drive point of the first sweep write cycle.
  task automatic sweep_check(input string name);
    for (int k = 0; k < 32; k++) begin
      sample();
      chk({name, "_wr"}, {bus.icache_tag_cen, bus.icache_tag_wen, bus.icache_tag_idx,
                          |bus.icache_tag_din, bus.lookup_rdy, bus.refill_rdy,
                          bus.inv_busy, bus.inv_done},
          {1'b1, 3'b111, 10'(k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      to_drive();
    end
    sample();
    chk({name, "_done"}, {bus.inv_busy, bus.inv_done, bus.lookup_rdy, bus.icache_tag_cen},
        {1'b0, 1'b1, 1'b0, 1'b0});
    to_drive();
    sample();
    chk({name, "_after"}, {bus.inv_busy, bus.inv_done, bus.lookup_rdy}, {1'b0, 1'b0, 1'b1});
    to_drive();
  endtask

  function automatic vec_t mk_rf(input logic [9:0] idx, input logic [21:0] tag, input logic way);
    vec_t v;
    v.is_lk = 1'b0;
    v.idx   = idx;
    v.tag   = tag;
    v.way   = way;
    v.exp   = '0;
    return v;
  endfunction

  function automatic vec_t mk_lk(input logic [9:0] idx, input logic [21:0] tag, input rsp_t exp);
    vec_t v;
    v.is_lk = 1'b1;
    v.idx   = idx;
    v.tag   = tag;
    v.way   = 1'b0;
    v.exp   = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.refill_req = ~v.is_lk;
    bus.lookup_req = v.is_lk;
    bus.refill_idx = v.idx;
    bus.refill_tag = v.tag;
    bus.refill_way = v.way;
    bus.lookup_idx = v.idx;
    bus.lookup_tag = v.tag;
    cur_exp        = v.exp;
    sample();
    chk("vec_rdy", v.is_lk ? bus.lookup_rdy : bus.refill_rdy, 1'b1);
    to_drive();
  endtask

  task automatic idle_in();
    bus.refill_req  = 1'b0;
    bus.lookup_req  = 1'b0;
    bus.inv_all_req = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.inv_all_req = 1'b1;
    bus.refill_req  = 1'b1;
    bus.lookup_req  = 1'b1;
    bus.refill_idx  = 10'd3;
    bus.refill_tag  = 22'h1;
    bus.refill_way  = 1'b0;
    bus.lookup_idx  = 10'd0;
    bus.lookup_tag  = 22'h0;
    cur_exp         = '0;

    // Reset: outputs quiet even with every request asserted.
    to_drive();
    to_drive();
    sample();
    chk("reset_outs", {bus.inv_busy, bus.inv_done, bus.lookup_resp_vld, bus.refill_rdy,
                       bus.lookup_rdy, bus.icache_tag_cen, bus.icache_tag_wen},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000});
    chk("reset_idx", bus.icache_tag_idx, 10'd0);
    chk("reset_din", bus.icache_tag_din, 47'd0);
    to_drive();

    // Power-on sweep; a lookup held pending is accepted right after inv_done.
    rst             = 1'b0;
    bus.inv_all_req = 1'b0;
    bus.refill_req  = 1'b0;
    bus.lookup_req  = 1'b1;
    cur_exp         = 4'b0000;
    sweep_check("sweep_por");
    idle_in();

    vt.push_back(mk_rf(10'd5,  22'h12345,  1'b1));
    vt.push_back(mk_lk(10'd5,  22'h12345,  4'b1100));
    vt.push_back(mk_rf(10'd7,  22'h00AAA,  1'b0));
    vt.push_back(mk_rf(10'd7,  22'h00BBB,  1'b1));
    vt.push_back(mk_lk(10'd7,  22'h00001,  4'b0000));
    vt.push_back(mk_rf(10'd7,  22'h00CCC,  1'b0));
    vt.push_back(mk_lk(10'd7,  22'h00001,  4'b0010));
    vt.push_back(mk_lk(10'd7,  22'h00CCC,  4'b1010));
    vt.push_back(mk_lk(10'd7,  22'h00BBB,  4'b1110));
    vt.push_back(mk_rf(10'd1,  22'h3FFFFF, 1'b0));
    vt.push_back(mk_rf(10'd31, 22'h00002,  1'b0));
    vt.push_back(mk_rf(10'd1,  22'h3FFFFF, 1'b1));
    vt.push_back(mk_lk(10'd1,  22'h3FFFFF, 4'b1001));
    vt.push_back(mk_lk(10'd2,  22'h00000,  4'b0000));
    vt.push_back(mk_lk(10'd3,  22'h00000,  4'b0000));
    vt.push_back(mk_lk(10'd31, 22'h00002,  4'b1010));
    vt.push_back(mk_lk(10'h3E5, 22'h12345, 4'b1100));
    // Lookup then same-index refill: the lookup sees pre-refill data.
    vt.push_back(mk_lk(10'd5,  22'h00777,  4'b0000));
    vt.push_back(mk_rf(10'd5,  22'h00777,  1'b0));
    vt.push_back(mk_lk(10'd5,  22'h00777,  4'b1010));
    for (int i = 0; i < vt.size(); i++) apply(vt[i]);
    idle_in();
    repeat (3) cyc();

    // Refill and lookup together: refill wins, lookup taken the next cycle.
    bus.refill_req = 1'b1;
    bus.refill_idx = 10'd9;
    bus.refill_tag = 22'h00055;
    bus.refill_way = 1'b0;
    bus.lookup_req = 1'b1;
    bus.lookup_idx = 10'd9;
    bus.lookup_tag = 22'h00055;
    cur_exp        = 4'b1010;
    sample();
    chk("sim_rdy", {bus.refill_rdy, bus.lookup_rdy}, 2'b10);
    to_drive();
    bus.refill_req = 1'b0;
    sample();
    chk("sim_lookup_next", bus.lookup_rdy, 1'b1);
    to_drive();
    idle_in();
    repeat (3) cyc();

    // Invalidate request behind an in-flight lookup.
    apply(mk_lk(10'd5, 22'h00777, 4'b1010));
    bus.inv_all_req = 1'b1;
    bus.lookup_req  = 1'b1;
    bus.refill_req  = 1'b0;
    sample();
    chk("inv_prio", {bus.refill_rdy, bus.lookup_rdy, bus.icache_tag_cen}, 3'b000);
    to_drive();
    idle_in();
    sweep_check("sweep_inv");
    apply(mk_lk(10'd5, 22'h12345, 4'b0000));
    idle_in();
    repeat (3) cyc();

    // Reset landing on sweep index 12 restarts the sweep.
    bus.inv_all_req = 1'b1;
    cyc();
    idle_in();
    for (int k = 0; k < 12; k++) begin
      sample();
      chk("sweep_pre_wr", {bus.icache_tag_cen, bus.icache_tag_wen, bus.icache_tag_idx,
                           bus.inv_done}, {1'b1, 3'b111, 10'(k), 1'b0});
      to_drive();
    end
    rst = 1'b1;
    sample();
    chk("rst_mid", {bus.icache_tag_cen, bus.icache_tag_wen, bus.icache_tag_idx,
                    bus.inv_busy, bus.inv_done}, {1'b0, 3'b000, 10'd0, 1'b1, 1'b0});
    to_drive();
    rst = 1'b0;
    sweep_check("sweep_rst");

    apply(mk_lk(10'd7, 22'h00CCC, 4'b0000));
    idle_in();
    repeat (4) cyc();
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
